// File: rtl/stage1_fetch_ctrl_if.sv
// Fetch-side bundle: EX redirect, instruction-memory request/response, decode hand-off.
// master = fetch controller, slave = surrounding core/imem environment.
interface stage1_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [31:0]     imem_rsp_data_i;
  logic            imem_rsp_err_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_hoff_o;
  logic            inst_err_o;

  modport master (
    input  redirect_i, redirect_pc_i,
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_hoff_o, inst_err_o,
    input  inst_ready_i
  );

  modport slave (
    output redirect_i, redirect_pc_i,
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_hoff_o, inst_err_o,
    output inst_ready_i
  );
endinterface

// File: rtl/stage1_fetch_ctrl.sv
// Fetch controller: issues word-aligned imem requests, queues in-order responses for
// decode, and squashes queued/in-flight fetches on an EX redirect or after an access fault.
module stage1_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int              FQ_DEPTH     = 4,
  parameter int              MAX_OUTST    = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  stage1_fetch_ctrl_if.master bus
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 2) + 1;

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;
  state_t state_q, state_nx;

  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q, pend_addr_q;
  logic            pend_q, pend_old_q, hoff_q;
  logic [CW-1:0]   outst_q, stale_q, count_q, outst_nx, stale_nx;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;

  logic [31:0]     fq_data [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc   [FQ_DEPTH];
  logic            fq_hoff [FQ_DEPTH];
  logic            fq_err  [FQ_DEPTH];

  logic can_issue, req_valid, req_acc, req_hold, rsp_in, enq, deq, err_enq, squash;

  // A held request keeps its address; pend_old marks one issued before a redirect,
  // whose address no longer matches fetch_pc.
  always_comb begin
    can_issue = (state_q == FETCH) && (outst_q < CW'(MAX_OUTST)) &&
                ((outst_q + count_q) < CW'(FQ_DEPTH)) && !bus.redirect_i;
    req_valid = pend_q | can_issue;
    req_acc   = req_valid & bus.imem_req_ready_i;
    req_hold  = req_valid & ~bus.imem_req_ready_i;
    rsp_in    = bus.imem_rsp_valid_i;
    enq       = rsp_in & ~bus.redirect_i & (stale_q == '0) & (state_q == FETCH);
    err_enq   = enq & bus.imem_rsp_err_i;
    deq       = (count_q != '0) & bus.inst_ready_i;
    outst_nx  = outst_q + CW'(req_acc) - CW'(rsp_in);
    squash    = bus.redirect_i | err_enq;
    // Every request still in flight or pending after a squash is stale.
    if (squash)                       stale_nx = outst_nx + CW'(req_hold);
    else if (rsp_in && stale_q != '0) stale_nx = stale_q - CW'(1);
    else                              stale_nx = stale_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      BOOT:    state_nx = FETCH;
      FETCH:   if (err_enq) state_nx = HALT;
      DRAIN:   if (stale_nx == '0) state_nx = FETCH;
      default: state_nx = state_q;
    endcase
    if (bus.redirect_i) state_nx = (stale_nx != '0) ? DRAIN : FETCH;
  end

  always_comb begin
    bus.imem_req_valid_o = req_valid;
    bus.imem_req_addr_o  = pend_old_q ? pend_addr_q : fetch_pc_q;
    bus.inst_valid_o     = (count_q != '0);
    bus.inst_o           = bus.inst_valid_o ? fq_data[rd_ptr_q] : '0;
    bus.inst_pc_o        = bus.inst_valid_o ? fq_pc[rd_ptr_q]   : '0;
    bus.inst_hoff_o      = bus.inst_valid_o & fq_hoff[rd_ptr_q];
    bus.inst_err_o       = bus.inst_valid_o & fq_err[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_old_q <= 1'b0;
      hoff_q     <= 1'b0;
      outst_q    <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      outst_q    <= outst_nx;
      stale_q    <= stale_nx;
      pend_q     <= req_hold;
      pend_old_q <= req_hold & (bus.redirect_i | pend_old_q);
      if (bus.redirect_i) begin
        fetch_pc_q <= bus.redirect_pc_i & ~XLEN'(3);
        rsp_pc_q   <= bus.redirect_pc_i & ~XLEN'(3);
        hoff_q     <= bus.redirect_pc_i[1];
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (req_acc && !pend_old_q) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (enq) begin
          rsp_pc_q <= rsp_pc_q + XLEN'(4);
          hoff_q   <= 1'b0;
        end
        wr_ptr_q <= wr_ptr_q + PW'(enq);
        rd_ptr_q <= rd_ptr_q + PW'(deq);
        count_q  <= count_q + CW'(enq) - CW'(deq);
      end
    end
  end

  // Queue storage and the held request address carry no reset; outputs are masked by valid.
  always_ff @(posedge clk_i) begin
    pend_addr_q <= bus.imem_req_addr_o;
    if (enq) begin
      fq_data[wr_ptr_q] <= bus.imem_rsp_data_i;
      fq_pc[wr_ptr_q]   <= rsp_pc_q;
      fq_hoff[wr_ptr_q] <= hoff_q;
      fq_err[wr_ptr_q]  <= bus.imem_rsp_err_i;
    end
  end

  a_rsp_needs_outst: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rsp_valid_i |-> (outst_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(enq && !deq && count_q == CW'(FQ_DEPTH)));

endmodule
